// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 PLL
// dynamic phase-shift controller.
package pll_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t SETUP  = 3'd1;
    localparam state_t STEP   = 3'd2;
    localparam state_t GAP    = 3'd3;
    localparam state_t SETTLE = 3'd4;
    localparam state_t DONE   = 3'd5;

    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;

    localparam int DEF_SETUP_CYCLES = 2;
    localparam int DEF_STEP_LOW     = 2;
    localparam int DEF_STEP_GAP     = 4;
    localparam int DEF_LOCK_STABLE  = 8;
    localparam int DEF_LOCK_TIMEOUT = 4095;

    localparam int TMR_W    = 8;
    localparam int LOCK_W   = 8;
    localparam int SETTLE_W = 12;

    // One fine step of phase position, wrapping mod 8
    function automatic logic [2:0] posStep(
        input logic [2:0] pos,
        input logic       dir
    );
        return dir ? pos + 3'd1 : pos - 3'd1;
    endfunction

endpackage

// File: rtl/ulx3s_pll_phase_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous
// status inputs such as PLL LOCK.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronization into clk
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ulx3s_pll_phase_ctrl.sv
// EHXPLLL dynamic phase-step sequencer.
// PAWS_PLL_PHASE_TRACK_EN enables position readback.
module ulx3s_pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int STEP_LOW     = DEF_STEP_LOW,
    parameter int STEP_GAP     = DEF_STEP_GAP,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [3:0] req_steps,
    input  logic       pll_locked,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [1:0] rd_sel,
    output logic [2:0] rd_pos
);

    state_t              state;
    logic [TMR_W-1:0]    tmr;
    logic [3:0]          stepCnt;
    logic [LOCK_W-1:0]   lockCnt;
    logic [SETTLE_W-1:0] settleCnt;
    logic [1:0]          selQ;
    logic                dirQ;
    logic                errQ;
    logic                doneQ;
    logic                stepQ;
    logic                lockS;
    logic                accept;
    logic                setupEnd;
    logic                stepEnd;
    logic                gapEnd;
    logic                lockEnd;
    logic                timeoutEnd;

    sync2 uLockSync (
        .clk   (clkin),
        .reset (reset),
        .d     (pll_locked),
        .q     (lockS)
    );

    assign req_ready     = (state == IDLE) && !reset;
    assign busy          = (state != IDLE);
    assign done          = doneQ;
    assign err           = errQ;
    assign pll_phasesel  = selQ;
    assign pll_phasedir  = dirQ;
    assign pll_phasestep = stepQ;

    assign accept = req_valid && req_ready;

    assign setupEnd = (state == SETUP)
        && (tmr == TMR_W'(SETUP_CYCLES - 1));
    assign stepEnd = (state == STEP)
        && (tmr == TMR_W'(STEP_LOW - 1));
    assign gapEnd = (state == GAP)
        && (tmr == TMR_W'(STEP_GAP - 1));
    assign lockEnd = lockS
        && (lockCnt == LOCK_W'(LOCK_STABLE - 1));
    assign timeoutEnd =
        (settleCnt == SETTLE_W'(LOCK_TIMEOUT - 1));

    // Sequencer: setup, pulse train, lock settle
    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= IDLE;
            tmr       <= '0;
            stepCnt   <= '0;
            lockCnt   <= '0;
            settleCnt <= '0;
            selQ      <= '0;
            dirQ      <= 1'b0;
            errQ      <= 1'b0;
            doneQ     <= 1'b0;
            stepQ     <= 1'b1;
        end else begin
            doneQ <= (state == DONE);
            stepQ <= (state != STEP);
            unique case (1'b1)
                (state == IDLE): begin
                    if (accept) begin
                        selQ      <= req_sel;
                        dirQ      <= req_dir;
                        stepCnt   <= req_steps;
                        errQ      <= 1'b0;
                        tmr       <= '0;
                        lockCnt   <= '0;
                        settleCnt <= '0;
                        state     <= (req_steps == 4'd0)
                            ? DONE : SETUP;
                    end
                end
                (state == SETUP): begin
                    if (setupEnd) begin
                        tmr   <= '0;
                        state <= STEP;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                (state == STEP): begin
                    if (stepEnd) begin
                        tmr     <= '0;
                        stepCnt <= stepCnt - 4'd1;
                        state   <= GAP;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                (state == GAP): begin
                    if (gapEnd) begin
                        tmr   <= '0;
                        state <= (stepCnt != 4'd0)
                            ? STEP : SETTLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                (state == SETTLE): begin
                    settleCnt <= settleCnt + 1'b1;
                    lockCnt   <= lockS
                        ? lockCnt + 1'b1 : '0;
                    if (lockEnd) begin
                        state <= DONE;
                    end else if (timeoutEnd) begin
                        errQ  <= 1'b1;
                        state <= DONE;
                    end
                end
                (state == DONE): begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PAWS_PLL_PHASE_TRACK_EN
    logic [2:0] pos [SEL_CLKOP:SEL_CLKOS3];

    // Fine-phase position per output, bumped per pulse
    always_ff @(posedge clkin) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                pos[i] <= '0;
            end
        end else if (stepEnd) begin
            pos[selQ] <= posStep(pos[selQ], dirQ);
        end
    end

    assign rd_pos = pos[rd_sel];
`else
    logic unusedRdSel;

    assign unusedRdSel = ^rd_sel;
    assign rd_pos      = 3'd0;
`endif

endmodule

// File: doc/ulx3s_pll_phase_ctrl.md
# ulx3s_pll_phase_ctrl

Dynamic phase-shift controller for the ECP5 EHXPLLL that generates the PAWS CPU clocks. It accepts step requests over a valid/ready handshake and drives the PLL's PHASESEL/PHASEDIR/PHASESTEP pins with correct setup, pulse and gap timing. After each request it waits for PLL lock to be re-established. Optionally it tracks the fine-phase position of each of the four outputs. It sits in the clock module, clocked from the 25 MHz reference, next to the PLL instance.

## Interface
Parameters:
- SETUP_CYCLES, 2, cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP pulse
- STEP_LOW, 2, PHASESTEP low-pulse width in cycles
- STEP_GAP, 4, PHASESTEP high cycles between consecutive pulses
- LOCK_STABLE, 8, consecutive synchronized-lock cycles required to finish
- LOCK_TIMEOUT, 4095, maximum settle cycles before error; settle counter is 12 bits

Ports:
- clkin  in  1  25 MHz reference clock; single clock domain
- reset  in  1  synchronous, active-high
- req_valid  in  1  step request
- req_ready  out  1  high only in IDLE
- req_sel  in  2  target output: 0 CLKOP, 1 CLKOS, 2 CLKOS2, 3 CLKOS3
- req_dir  in  1  passed to PHASEDIR (1 lead, 0 lag)
- req_steps  in  4  number of fine steps, 0..15
- pll_locked  in  1  raw PLL LOCK; asynchronous
- pll_phasesel  out  2  to PHASESEL1:0
- pll_phasedir  out  1  to PHASEDIR
- pll_phasestep  out  1  to PHASESTEP; idle high, active-low pulse
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse on completion
- err  out  1  sticky lock-timeout flag
- rd_sel  in  2  position readback select
- rd_pos  out  3  fine-phase position of output rd_sel, modulo 8

## Operation
- pll_locked passes through a 2-flop synchronizer before any use; this makes lock_s 2 cycles late.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch sel/dir/steps into pll_phasesel/pll_phasedir/step counter and clear err. steps==0 goes to DONE; otherwise go to SETUP.
  - SETUP: hold SETUP_CYCLES cycles, then go to STEP.
  - STEP: pll_phasestep=0 for STEP_LOW cycles, decrement step counter, then go to GAP.
  - GAP: pll_phasestep=1 for STEP_GAP cycles. Go to STEP if counter≠0, else go to SETTLE.
  - SETTLE: count consecutive lock_s=1 cycles; any lock_s=0 resets this count. Reaching LOCK_STABLE goes to DONE. The settle counter counts every SETTLE cycle; reaching LOCK_TIMEOUT sets err and goes to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- pll_phasesel/pll_phasedir change only on request accept. They hold their value through IDLE until the next accept.
- Position tracking: on each completed STEP, pos[sel] ± 1 mod 8 (+ if dir=1), wrapping 7→0 and 0→7.
- A request presented while busy is not accepted; req_ready=0 and the requester holds.
- Lock loss in IDLE is ignored; the block only samples lock in SETTLE.

## Timing
- Reset values: state IDLE, req_ready=1 (while reset low), busy=0, done=0, err=0, pll_phasestep=1, pll_phasesel=0, pll_phasedir=0, all pos=0, counters 0.
- req_ready is 0 during reset.
- Reset mid-operation: pll_phasestep is high on the next edge, the in-flight request is abandoned and positions are cleared.
- First PHASESTEP falling edge occurs SETUP_CYCLES+1 cycles after the accept edge.
- Latency for N≥1 steps with lock steady high: 1 + SETUP_CYCLES + N·(STEP_LOW+STEP_GAP) + LOCK_STABLE cycles from accept to done. With defaults this is 11+6N.
- steps==0: done pulses 1 cycle after accept; pins do not toggle.
- Back-to-back requests: the next accept is earliest on the cycle after done.

## Configuration
- PAWS_PLL_PHASE_TRACK_EN defined: position registers and rd_pos are live.
- Not defined: no position registers; rd_pos is tied to 0; rd_sel is unused; all other behaviour is identical.

## Structure
- A shared package, pll_ctrl_pkg, holds:
  - the state enum (IDLE, SETUP, STEP, GAP, SETTLE, DONE)
  - output-select constants (SEL_CLKOP=0 … SEL_CLKOS3=3)
  - default timing constants
- One sub-module, sync2, is the 2-flop synchronizer for pll_locked, reused for other asynchronous status inputs.

## Test plan
- Reset, then idle: pll_phasestep=1, req_ready=1, busy=0, rd_pos=0 for all selects.
- Request sel=1, dir=1, steps=3 with lock held high: exactly 3 low pulses of 2 cycles, 4 cycles apart. The first falls 3 cycles after accept. pll_phasesel=1 throughout. done arrives at cycle 29; rd_pos(1)=3.
- Request sel=2, dir=0, steps=1 from position 0: rd_pos(2)=7 (wrap). A following dir=1, steps=9 request leaves rd_pos(2)=0.
- Drop lock for the whole of SETTLE: err=1 and done after 4095 settle cycles. The next accept clears err.
- Lock glitch low mid-SETTLE: the stable count restarts, done is delayed by the glitch length plus 8 cycles, and err stays 0.
- Assert reset during STEP: pll_phasestep=1 on the next edge, busy=0, and the request is not completed.
